// File: rtl/mux_sel_scheduler_pkg.sv
// Shared widths, constants and FSM encoding for the sparse mux select scheduler.
package mux_sched_pkg;

    localparam int NUM_IN = 16;
    localparam int SEL_W  = $clog2(NUM_IN + 1);
    localparam int IDX_W  = $clog2(NUM_IN);
    localparam int GRP_W  = 8;

    // Select value that routes the constant-zero leg of the 17-to-1 mux.
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(NUM_IN);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/mux_sel_scheduler_lsb_prio_enc.sv
// Lowest-set-bit priority encoder with any / exactly-one flags.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module lsb_prio_enc
    import mux_sched_pkg::*;
(
    input  logic [NUM_IN-1:0] vec,
    output logic [IDX_W-1:0]  idx,
    output logic              any,
    output logic              one_hot
);

    always_comb begin
        idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any     = |vec;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign one_hot = any && ((vec & (vec - NUM_IN'(1))) == '0);

endmodule

// File: rtl/mux_sel_scheduler.sv
// Issues one mux select per set mask bit (lowest first), zero-select for empty groups.
// Latency: 1 cycle from mask accept to first beat; one beat per cycle, no bubble between groups.
// Backpressure: beats hold while out_ready is low; in_ready only in IDLE or on the taken last beat.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int GRP_CNT_W = GRP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NUM_IN-1:0]    in_mask,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_last,
    output logic [3:0]           out_beat,
    input  logic                 out_ready,
    output logic [GRP_CNT_W-1:0] grp_cnt
);

    sched_state_t         state_q, state_d;
    logic [NUM_IN-1:0]    rem_q, rem_d;
    logic [3:0]           beat_q, beat_d;
    logic                 zflag_q, zflag_d;
    logic [GRP_CNT_W-1:0] grp_q, grp_d;

    logic [IDX_W-1:0] low_idx;
    logic             rem_any;
    logic             rem_one;
    logic             out_hs;

    lsb_prio_enc u_enc (
        .vec     (rem_q),
        .idx     (low_idx),
        .any     (rem_any),
        .one_hot (rem_one)
    );

    // rem is zero both in IDLE and for an empty group, so both present ZERO_SEL.
    assign out_valid = (state_q == ISSUE);
    assign out_sel   = rem_any ? SEL_W'(low_idx) : ZERO_SEL;
    assign out_last  = out_valid && (zflag_q || rem_one);
    assign out_beat  = beat_q;
    assign grp_cnt   = grp_q;

    assign out_hs   = out_valid && out_ready;
    assign in_ready = (state_q == IDLE) || (out_hs && out_last);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        zflag_d = zflag_q;
        grp_d   = grp_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ISSUE;
                    rem_d   = in_mask;
                    beat_d  = '0;
                    zflag_d = (in_mask == '0);
                end
            end
            ISSUE: begin
                if (out_hs) begin
                    if (out_last) begin
                        grp_d = grp_q + GRP_CNT_W'(1);
                        if (in_valid) begin
                            rem_d   = in_mask;
                            beat_d  = '0;
                            zflag_d = (in_mask == '0);
                        end else begin
                            state_d = IDLE;
                            rem_d   = '0;
                            beat_d  = '0;
                            zflag_d = 1'b0;
                        end
                    end else begin
                        rem_d  = rem_q & (rem_q - NUM_IN'(1));
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            beat_q  <= '0;
            zflag_q <= 1'b0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            zflag_q <= zflag_d;
            grp_q   <= grp_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed self-checking bench for mux_sel_scheduler.
module tb_mux_sel_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_mask;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_sel;
    logic        out_last;
    logic [3:0]  out_beat;
    logic        out_ready;
    logic [7:0]  grp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mux_sel_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .out_ready (out_ready),
        .grp_cnt   (grp_cnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable when this returns.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer_mask(input logic [15:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        step();
        in_valid = 1'b0;
        in_mask  = 16'hDEAD;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
        n_checks++; if (out_sel !== 5'd16) begin n_fail++; $display("FAIL rst_sel got %0d exp 16", out_sel); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %0h exp 0", out_last); end
        n_checks++; if (out_beat !== 4'd0) begin n_fail++; $display("FAIL rst_beat got %0d exp 0", out_beat); end
        n_checks++; if (grp_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_grp got %0d exp 0", grp_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_sparse();
        logic [4:0] exp_sel [4] = '{5'd0, 5'd5, 5'd10, 5'd15};
        out_ready = 1'b1;
        offer_mask(16'h8421);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sparse_valid[%0d] got %0h exp 1", i, out_valid); end
            n_checks++; if (out_sel !== exp_sel[i]) begin n_fail++; $display("FAIL sparse_sel[%0d] got %0d exp %0d", i, out_sel, exp_sel[i]); end
            n_checks++; if (out_beat !== 4'(i)) begin n_fail++; $display("FAIL sparse_beat[%0d] got %0d exp %0d", i, out_beat, i); end
            n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL sparse_last[%0d] got %0h exp %0h", i, out_last, (i == 3)); end
            n_checks++; if (grp_cnt !== 8'd0) begin n_fail++; $display("FAIL sparse_grp_mid[%0d] got %0d exp 0", i, grp_cnt); end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_idle got %0h exp 0", out_valid); end
        n_checks++; if (grp_cnt !== 8'd1) begin n_fail++; $display("FAIL sparse_grp got %0d exp 1", grp_cnt); end
    endtask

    task automatic test_zero_group();
        offer_mask(16'h0000);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %0h exp 1", out_valid); end
        n_checks++; if (out_sel !== 5'd16) begin n_fail++; $display("FAIL zero_sel got %0d exp 16", out_sel); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL zero_last got %0h exp 1", out_last); end
        n_checks++; if (out_beat !== 4'd0) begin n_fail++; $display("FAIL zero_beat got %0d exp 0", out_beat); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_idle got %0h exp 0", out_valid); end
        n_checks++; if (grp_cnt !== 8'd2) begin n_fail++; $display("FAIL zero_grp got %0d exp 2", grp_cnt); end
    endtask

    task automatic test_back_to_back();
        offer_mask(16'hFFFF);
        in_valid = 1'b1;
        in_mask  = 16'h0002;
        #1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0h exp 1", i, out_valid); end
            n_checks++; if (out_sel !== 5'(i)) begin n_fail++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", i, out_sel, i); end
            n_checks++; if (out_beat !== 4'(i)) begin n_fail++; $display("FAIL b2b_beat[%0d] got %0d exp %0d", i, out_beat, i); end
            n_checks++; if (out_last !== (i == 15)) begin n_fail++; $display("FAIL b2b_last[%0d] got %0h exp %0h", i, out_last, (i == 15)); end
            n_checks++; if (in_ready !== (i == 15)) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0h exp %0h", i, in_ready, (i == 15)); end
            step();
        end
        in_valid = 1'b0;
        in_mask  = 16'hFFFF;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_next_valid got %0h exp 1", out_valid); end
        n_checks++; if (out_sel !== 5'd1) begin n_fail++; $display("FAIL b2b_next_sel got %0d exp 1", out_sel); end
        n_checks++; if (out_beat !== 4'd0) begin n_fail++; $display("FAIL b2b_next_beat got %0d exp 0", out_beat); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL b2b_next_last got %0h exp 1", out_last); end
        n_checks++; if (grp_cnt !== 8'd3) begin n_fail++; $display("FAIL b2b_grp_mid got %0d exp 3", grp_cnt); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %0h exp 0", out_valid); end
        n_checks++; if (grp_cnt !== 8'd4) begin n_fail++; $display("FAIL b2b_grp got %0d exp 4", grp_cnt); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        offer_mask(16'h0300);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %0h exp 1", i, out_valid); end
            n_checks++; if (out_sel !== 5'd8) begin n_fail++; $display("FAIL stall_sel[%0d] got %0d exp 8", i, out_sel); end
            n_checks++; if (out_beat !== 4'd0) begin n_fail++; $display("FAIL stall_beat[%0d] got %0d exp 0", i, out_beat); end
            n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL stall_last[%0d] got %0h exp 0", i, out_last); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %0h exp 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_sel !== 5'd8) begin n_fail++; $display("FAIL stall_rel_sel got %0d exp 8", out_sel); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rel_in_ready got %0h exp 0", in_ready); end
        step();
        n_checks++; if (out_sel !== 5'd9) begin n_fail++; $display("FAIL stall_sel2 got %0d exp 9", out_sel); end
        n_checks++; if (out_beat !== 4'd1) begin n_fail++; $display("FAIL stall_beat2 got %0d exp 1", out_beat); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL stall_last2 got %0h exp 1", out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready2 got %0h exp 1", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %0h exp 0", out_valid); end
        n_checks++; if (grp_cnt !== 8'd5) begin n_fail++; $display("FAIL stall_grp got %0d exp 5", grp_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        offer_mask(16'h00F0);
        n_checks++; if (out_sel !== 5'd4) begin n_fail++; $display("FAIL arst_sel0 got %0d exp 4", out_sel); end
        step();
        n_checks++; if (out_sel !== 5'd5) begin n_fail++; $display("FAIL arst_sel1 got %0d exp 5", out_sel); end
        step();
        n_checks++; if (out_beat !== 4'd2) begin n_fail++; $display("FAIL arst_beat2 got %0d exp 2", out_beat); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0h exp 0", out_valid); end
        n_checks++; if (out_sel !== 5'd16) begin n_fail++; $display("FAIL arst_sel got %0d exp 16", out_sel); end
        n_checks++; if (out_beat !== 4'd0) begin n_fail++; $display("FAIL arst_beat got %0d exp 0", out_beat); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL arst_last got %0h exp 0", out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %0h exp 1", in_ready); end
        n_checks++; if (grp_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_grp got %0d exp 0", grp_cnt); end
        step();
        reset = 1'b0;
        step();
        offer_mask(16'h0001);
        n_checks++; if (out_sel !== 5'd0) begin n_fail++; $display("FAIL arst_new_sel got %0d exp 0", out_sel); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL arst_new_last got %0h exp 1", out_last); end
        step();
        n_checks++; if (grp_cnt !== 8'd1) begin n_fail++; $display("FAIL arst_new_grp got %0d exp 1", grp_cnt); end
    endtask

    task automatic test_grp_wrap();
        logic [7:0] exp_grp;
        exp_grp   = 8'd1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 16'h8000;
        step();
        for (int k = 0; k < 255; k++) begin
            n_checks++; if (out_sel !== 5'd15 || out_last !== 1'b1) begin n_fail++; $display("FAIL wrap_beat[%0d] got sel %0d last %0h exp 15 1", k, out_sel, out_last); end
            n_checks++; if (grp_cnt !== exp_grp) begin n_fail++; $display("FAIL wrap_grp[%0d] got %0d exp %0d", k, grp_cnt, exp_grp); end
            if (k == 254) begin
                in_valid = 1'b0;
                n_checks++; if (grp_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_pre got %0d exp 255", grp_cnt); end
            end
            step();
            exp_grp = exp_grp + 8'd1;
        end
        n_checks++; if (grp_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %0d exp 0", grp_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got %0h exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_zero_group();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_grp_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
